// File: rtl/csa_resolver_pkg.sv
// csa_resolver_pkg: shared state encodings and digit-step count helper for the carry-save blocks
package csa_resolver_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   function automatic int nd_calc(input int w, input int d);
      return (w + d) / d;
   endfunction
endpackage

// File: rtl/csa_resolver_if.sv
// csa_resolver_if: operand and result valid/ready channels of the resolver
interface csa_resolver_if #(parameter int W = 8);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] s_vec;
   logic [W-1:0] c_vec;
   logic         out_valid;
   logic         out_ready;
   logic [W+1:0] result;
   modport master (output in_valid, s_vec, c_vec, out_ready, input in_ready, out_valid, result);
   modport slave (input in_valid, s_vec, c_vec, out_ready, output in_ready, out_valid, result);
endinterface

// File: rtl/csa_resolver_digit_add.sv
// csa_digit_add: combinational DIGIT-bit adder with carry in and carry out
module csa_digit_add #(parameter int DIGIT = 2) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout
);
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
endmodule

// File: rtl/csa_resolver.sv
// csa_resolver: resolves a carry-save sum/carry pair to binary, DIGIT bits per clock
module csa_resolver
   import csa_resolver_pkg::*;
#(
   parameter int W     = 8,
   parameter int DIGIT = 2
) (
   input logic           clk,
   input logic           rst,
   csa_resolver_if.slave bus
);
   localparam int ND = nd_calc(W, DIGIT);
   localparam int NB = ND * DIGIT;
   localparam int CW = ND > 1 ? $clog2(ND) : 1;
   state_t           state, next;
   logic [NB-1:0]    a, b, res;
   logic [NB:0]      full;
   logic [CW-1:0]    cnt;
   logic             carry, dcout, last, accept;
   logic [DIGIT-1:0] dsum;
   csa_digit_add #(.DIGIT(DIGIT)) u_add (
      .a(a[DIGIT-1:0]), .b(b[DIGIT-1:0]), .cin(carry), .sum(dsum), .cout(dcout)
   );
   assign last   = cnt == CW'(ND - 1);
   assign accept = state == IDLE && bus.in_valid;
   assign full   = {carry, res};
   assign bus.result = full[W+1:0];
   always_ff @(posedge clk) state <= rst ? IDLE : next;
   always_comb begin
      bus.in_ready  = state == IDLE;
      bus.out_valid = state == DONE;
      next = state == IDLE ? (bus.in_valid ? RUN : IDLE) :
             state == RUN  ? (last ? DONE : RUN) :
             state == DONE ? (bus.out_ready ? IDLE : DONE) : IDLE;
   end
   // operands shift down so the adder always sees the current digit at bit 0;
   // resolved digits enter res from the top and land in place after ND steps
   always_ff @(posedge clk) begin
      if (rst) begin
         a     <= '0;
         b     <= '0;
         res   <= '0;
         cnt   <= '0;
         carry <= 1'b0;
      end else if (accept) begin
         a     <= NB'(bus.s_vec);
         b     <= NB'({bus.c_vec, 1'b0});
         cnt   <= '0;
         carry <= 1'b0;
      end else if (state == RUN) begin
         a     <= a >> DIGIT;
         b     <= b >> DIGIT;
         res   <= NB'({dsum, res} >> DIGIT);
         carry <= dcout;
         cnt   <= cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_csa_resolver.sv
// tb_csa_resolver: directed table, corner-case sequences and random sweep against s+2*c
module tb_csa_resolver;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   passed = 0;
   csa_resolver_if #(.W(8)) bus ();
   csa_resolver #(.W(8), .DIGIT(2)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic [7:0] s;
      logic [7:0] c;
      logic [9:0] exp;
   } vec_t;
   vec_t vecs[9];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else passed++;
   endtask
   task automatic send(input logic [7:0] s, input logic [7:0] c);
      bus.in_valid = 1'b1;
      bus.s_vec    = s;
      bus.c_vec    = c;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask
   task automatic wait_out(output int cyc);
      cyc = 1;
      while (!bus.out_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
   endtask
   task automatic take();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask
   initial begin
      int         cyc, n;
      logic       done, seen;
      logic [7:0] s, c;
      logic [9:0] exp, cap;
      vecs[0] = '{8'h00, 8'h00, 10'h000};
      vecs[1] = '{8'hFF, 8'hFF, 10'h2FD};
      vecs[2] = '{8'hA5, 8'h5A, 10'h159};
      vecs[3] = '{8'h01, 8'h01, 10'h003};
      vecs[4] = '{8'h80, 8'h40, 10'h100};
      vecs[5] = '{8'h10, 8'h08, 10'h020};
      vecs[6] = '{8'h7F, 8'h80, 10'h17F};
      vecs[7] = '{8'hFF, 8'h00, 10'h0FF};
      vecs[8] = '{8'h00, 8'hFF, 10'h1FE};
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.s_vec     = '0;
      bus.c_vec     = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset in_ready", 32'(bus.in_ready), 1);
      chk("reset out_valid", 32'(bus.out_valid), 0);
      chk("reset result", 32'(bus.result), 0);
      foreach (vecs[i]) begin
         send(vecs[i].s, vecs[i].c);
         wait_out(cyc);
         chk($sformatf("vec%0d latency", i), 32'(cyc), 6);
         chk($sformatf("vec%0d result", i), 32'(bus.result), 32'(vecs[i].exp));
         take();
         chk($sformatf("vec%0d idle", i), 32'(bus.in_ready), 1);
      end
      // output stall: result and handshakes frozen while out_ready is low
      send(8'hA5, 8'h5A);
      wait_out(cyc);
      for (int k = 0; k < 10; k++) begin
         chk("stall result", 32'(bus.result), 32'h159);
         chk("stall in_ready", 32'(bus.in_ready), 0);
         chk("stall out_valid", 32'(bus.out_valid), 1);
         bus.in_valid = 1'b1;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      take();
      // back-to-back with in_valid held high
      bus.in_valid  = 1'b1;
      bus.s_vec     = 8'h01;
      bus.c_vec     = 8'h01;
      bus.out_ready = 1'b1;
      @(negedge clk);
      wait_out(cyc);
      chk("b2b first latency", 32'(cyc), 6);
      chk("b2b first result", 32'(bus.result), 32'h003);
      chk("b2b done in_ready", 32'(bus.in_ready), 0);
      bus.s_vec = 8'h80;
      bus.c_vec = 8'h40;
      @(negedge clk);
      chk("b2b idle in_ready", 32'(bus.in_ready), 1);
      chk("b2b idle out_valid", 32'(bus.out_valid), 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("b2b second run", 32'(bus.in_ready), 0);
      wait_out(cyc);
      chk("b2b second latency", 32'(cyc), 6);
      chk("b2b second result", 32'(bus.result), 32'h100);
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("b2b end idle", 32'(bus.in_ready), 1);
      // reset during the second RUN step discards the operation
      send(8'hFF, 8'h01);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid rst in_ready", 32'(bus.in_ready), 1);
      chk("mid rst out_valid", 32'(bus.out_valid), 0);
      chk("mid rst result", 32'(bus.result), 0);
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         seen |= bus.out_valid;
         @(negedge clk);
      end
      chk("mid rst no out_valid", 32'(seen), 0);
      send(8'h10, 8'h08);
      wait_out(cyc);
      chk("post rst latency", 32'(cyc), 6);
      chk("post rst result", 32'(bus.result), 32'h020);
      take();
      // random sweep with random consumer backpressure
      for (int i = 0; i < 1000; i++) begin
         s   = 8'($urandom);
         c   = 8'($urandom);
         exp = 10'(s) + {1'b0, c, 1'b0};
         send(s, c);
         done = 1'b0;
         cap  = '0;
         n    = 0;
         while (!done && n < 100) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            if (bus.out_valid && bus.out_ready) begin
               done = 1'b1;
               cap  = bus.result;
            end
            @(negedge clk);
            n++;
         end
         bus.out_ready = 1'b0;
         chk($sformatf("rand%0d done", i), 32'(done), 1);
         chk($sformatf("rand%0d result s=%0h c=%0h", i, s, c), 32'(cap), 32'(exp));
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
